// File: rtl/serial_link_pkg.sv
// Shared constants and types for the Game Boy serial port (SB/SC registers).
package serial_link_pkg;

  localparam logic [15:0] SB_ADDR = 16'hFF01;
  localparam logic [15:0] SC_ADDR = 16'hFF02;

  localparam int SC_START   = 7;
  localparam int SC_CLKSEL  = 0;
  localparam int INT_SERIAL = 3;

  // 4.194304 MHz system clock / 8192 Hz link clock
  localparam int DEFAULT_CLK_DIV = 512;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER_INT = 2'd1,
    XFER_EXT = 2'd2
  } serial_state_t;

  function automatic logic [7:0] sc_readback(input logic busy, input logic clk_sel);
    return {busy, 6'b111111, clk_sel};
  endfunction

endpackage

// File: rtl/serial_link_if.sv
// CPU-side register interface of the serial port.
// sb_wr/sc_wr are single-cycle write strobes qualified by nothing else: the
// engine always accepts them (no ready), wdata is valid only while a strobe is high.
interface serial_link_if;
  logic [7:0] wdata;
  logic       sb_wr;
  logic       sc_wr;
  logic [7:0] sb_out;
  logic [7:0] sc_out;
  logic       serial_int;

  modport master (
    output wdata, sb_wr, sc_wr,
    input  sb_out, sc_out, serial_int
  );

  modport slave (
    input  wdata, sb_wr, sc_wr,
    output sb_out, sc_out, serial_int
  );
endinterface

// File: rtl/serial_clkgen.sv
// Link clock source: internal HALF divider or synchronised peer clock,
// producing one-cycle rise/fall strobes aligned with sclk_out changes.
module serial_clkgen
  import serial_link_pkg::*;
#(
  parameter int HALF = DEFAULT_CLK_DIV / 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_int,
  input  logic restart,
  input  logic int_mode,
  input  logic sclk_in,
  output logic sclk_out,
  output logic rise,
  output logic fall
);

  localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [DW-1:0] div_q;
  logic          sclk_q;
  // [0] first stage, [1] synchronised, [2] previous synchronised value
  logic [2:0]    ext_sync_q;
  logic          div_last;
  logic          int_rise, int_fall, ext_rise, ext_fall;

  assign div_last = (div_q == DW'(HALF - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      sclk_q     <= 1'b1;
      ext_sync_q <= 3'b111;
    end else begin
      ext_sync_q <= {ext_sync_q[1:0], sclk_in};
      if (!run_int) begin
        div_q  <= '0;
        sclk_q <= 1'b1;
      end else if (restart) begin
        div_q  <= '0;
        sclk_q <= 1'b0;
      end else if (div_last) begin
        div_q  <= '0;
        sclk_q <= ~sclk_q;
      end else begin
        div_q  <= div_q + DW'(1);
      end
    end
  end

  assign int_rise = div_last & ~sclk_q;
  assign int_fall = div_last &  sclk_q;
  assign ext_rise =  ext_sync_q[1] & ~ext_sync_q[2];
  assign ext_fall = ~ext_sync_q[1] &  ext_sync_q[2];

  assign rise     = int_mode ? int_rise : ext_rise;
  assign fall     = int_mode ? int_fall : ext_fall;
  assign sclk_out = sclk_q;

endmodule

// File: rtl/serial_link.sv
// Serial port engine: shifts SB out MSB-first while shifting the peer's bits in,
// then pulses serial_int for one cycle on completion.
module serial_link
  import serial_link_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic          clk,
  input  logic          rst,
  serial_link_if.slave  bus,
  output logic          sclk_out,
  output logic          sclk_oe,
  input  logic          sclk_in,
  input  logic          sin,
  output logic          sout,
  output serial_state_t state_dbg
);

  localparam int HALF = CLK_DIV / 2;

  serial_state_t state_q, state_d;
  logic [7:0]    sb_q, sb_d, sb_load;
  logic [2:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          clk_sel_q, clk_sel_d;
  logic          sout_q, sout_d;
  logic          int_q, int_d;
  logic          restart;
  logic [1:0]    sin_sync_q;
  logic          sin_sync;
  logic          rise, fall;

  assign sin_sync = sin_sync_q[1];
  // A same-cycle SB write lands before a starting SC write sees it.
  assign sb_load  = (bus.sb_wr && state_q == IDLE) ? bus.wdata : sb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sb_q       <= 8'h00;
      cnt_q      <= 3'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      clk_sel_q  <= 1'b0;
      sout_q     <= 1'b1;
      int_q      <= 1'b0;
      sin_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      sb_q       <= sb_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      clk_sel_q  <= clk_sel_d;
      sout_q     <= sout_d;
      int_q      <= int_d;
      sin_sync_q <= {sin_sync_q[0], sin};
    end
  end

  always_comb begin
    state_d   = state_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    busy_d    = busy_q;
    clk_sel_d = clk_sel_q;
    sout_d    = sout_q;
    int_d     = 1'b0;
    restart   = 1'b0;

    if (bus.sc_wr) begin
      clk_sel_d = bus.wdata[SC_CLKSEL];
      busy_d    = bus.wdata[SC_START];
      sb_d      = sb_load;
      cnt_d     = 3'd0;
      done_d    = 1'b0;
      if (bus.wdata[SC_START]) begin
        state_d = bus.wdata[SC_CLKSEL] ? XFER_INT : XFER_EXT;
        sout_d  = sb_load[7];
        restart = 1'b1;
      end else begin
        state_d = IDLE;
        sout_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          sb_d = sb_load;
        end
        XFER_INT, XFER_EXT: begin
          if (done_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            int_d   = 1'b1;
            sout_d  = 1'b1;
            done_d  = 1'b0;
            cnt_d   = 3'd0;
          end else if (rise) begin
            sb_d  = {sb_q[6:0], sin_sync};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) done_d = 1'b1;
          end else if (fall) begin
            sout_d = sb_q[7];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  serial_clkgen #(.HALF(HALF)) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .run_int  (state_d == XFER_INT),
    .restart  (restart),
    .int_mode (state_q == XFER_INT),
    .sclk_in  (sclk_in),
    .sclk_out (sclk_out),
    .rise     (rise),
    .fall     (fall)
  );

  assign bus.sb_out     = sb_q;
  assign bus.sc_out     = sc_readback(busy_q, clk_sel_q);
  assign bus.serial_int = int_q;
  assign sclk_oe        = clk_sel_q;
  assign sout           = sout_q;
  assign state_dbg      = state_q;

endmodule
